// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing constants and helpers for the RAM-backed FIFO controller.
package fifo_ctrl_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int DEPTH_DEF    = 4;
  localparam int OBUF_ENTRIES = 2;
  localparam int OBUF_CW      = $clog2(OBUF_ENTRIES + 1);

  function automatic int unsigned fifo_entries(input int unsigned depth);
    return 32'd1 << depth;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_out_skid_buf.sv
// Two-entry FIFO that absorbs RAM read data so the read stream can stall
// without losing a word already in flight from the RAM.
module out_skid_buf
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic [WIDTH-1:0]   cap_data,
  input  logic               pop,
  output logic [OBUF_CW-1:0] buf_cnt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data
);

  logic [WIDTH-1:0]   ent0_q, ent0_d;
  logic [WIDTH-1:0]   ent1_q, ent1_d;
  logic [OBUF_CW-1:0] cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;

  // The head is released before the capture lands, so a word captured during
  // a pop from a one-deep buffer becomes the new head directly.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (pop && (cnt_q != '0)) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - OBUF_CW'(1);
    end
    if (capture) begin
      if (cnt_d == '0) begin
        ent0_d = cap_data;
      end else begin
        ent1_d = cap_data;
      end
      cnt_d = cnt_d + OBUF_CW'(1);
    end
    out_valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q      <= '0;
      ent1_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign buf_cnt   = cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = ent0_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Turns a 2**DEPTH x WIDTH dual-port RAM into a synchronous valid/ready FIFO.
// Build option FIFO_AFULL_EN adds a registered almost_full flag at AFULL_THRESH.
module ram_fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
`ifdef FIFO_AFULL_EN
  ,
  parameter int AFULL_THRESH = 12
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ram_wr_en,
  output logic [DEPTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0] ram_wr_data,
  output logic             ram_rd_en,
  output logic [DEPTH-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0] ram_rd_data,
  output logic [DEPTH+1:0] level
`ifdef FIFO_AFULL_EN
  ,
  output logic             almost_full
`endif
);

  localparam int          ENTRIES  = fifo_entries(DEPTH);
  localparam logic [DEPTH:0] FULL_CNT = ENTRIES[DEPTH:0];

  logic [DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]     ram_cnt_q, ram_cnt_d;
  logic               rd_pending_q, rd_pending_d;
  logic [DEPTH+1:0]   level_q, level_d;
  logic [OBUF_CW-1:0] buf_cnt, buf_cnt_d;
  logic [OBUF_CW:0]   obuf_claim;
  logic               push, pop, rd_issue;

  assign in_ready = (ram_cnt_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Only issue a read if the buffer has a free slot for its data next cycle,
  // counting the word already in flight and the one leaving this cycle.
  assign obuf_claim = {1'b0, buf_cnt} + {{OBUF_CW{1'b0}}, rd_pending_q};
  assign rd_issue   = (ram_cnt_q != '0) &&
                      (obuf_claim < (OBUF_ENTRIES[OBUF_CW:0] + {{OBUF_CW{1'b0}}, pop}));

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = rd_issue;
  assign ram_rd_addr = rd_ptr_q;

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + DEPTH'(1) : wr_ptr_q;
    rd_ptr_d     = rd_issue ? rd_ptr_q + DEPTH'(1) : rd_ptr_q;
    ram_cnt_d    = ram_cnt_q + {{DEPTH{1'b0}}, push} - {{DEPTH{1'b0}}, rd_issue};
    rd_pending_d = rd_issue;
    buf_cnt_d    = buf_cnt + {{(OBUF_CW-1){1'b0}}, rd_pending_q}
                           - {{(OBUF_CW-1){1'b0}}, pop};
    level_d      = {1'b0, ram_cnt_d}
                 + {{(DEPTH+2-OBUF_CW){1'b0}}, buf_cnt_d}
                 + {{(DEPTH+1){1'b0}}, rd_pending_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      level_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      rd_pending_q <= rd_pending_d;
      level_q      <= level_d;
    end
  end

  assign level = level_q;

  // Reset clears rd_pending_q, so data returning for a pre-reset read is dropped.
  out_skid_buf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .capture   (rd_pending_q),
    .cap_data  (ram_rd_data),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

`ifdef FIFO_AFULL_EN
  localparam logic [DEPTH+1:0] AFULL_LVL = (DEPTH+2)'(AFULL_THRESH);

  logic almost_full_q, almost_full_d;

  assign almost_full_d = (level_d >= AFULL_LVL);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 16x8 RAM attached.
`timescale 1ns/1ps
module tb_ram_fifo_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         ram_wr_en, ram_rd_en;
  logic [D-1:0] ram_wr_addr, ram_rd_addr;
  logic [W-1:0] ram_wr_data;
  logic [W-1:0] ram_rd_data = '0;
  logic [D+1:0] level;
  logic         almost_full;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .level       (level)
`ifdef FIFO_AFULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

`ifndef FIFO_AFULL_EN
  assign almost_full = 1'b0;
`endif

  logic [W-1:0] ram_mem [16];

  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
  end

  logic [W-1:0] sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Handshakes sampled here complete on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      chk("level", 32'(level), 32'(sb.size()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("pop_empty", 32'(out_valid), 32'd0);
        else chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, vcnt;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wr_en",     32'(ram_wr_en), 32'd0);
    chk("rst_rd_en",     32'(ram_rd_en), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);

    // single word latency
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    chk("sp_wr_en",   32'(ram_wr_en),   32'd1);
    chk("sp_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("sp_wr_data", 32'(ram_wr_data), 32'hA5);
    chk("sp_rd_en_t", 32'(ram_rd_en),   32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sp_rd_en",    32'(ram_rd_en),   32'd1);
    chk("sp_rd_addr",  32'(ram_rd_addr), 32'd0);
    chk("sp_valid_t1", 32'(out_valid),   32'd0);
    @(negedge clk);
    chk("sp_valid_t2", 32'(out_valid),   32'd0);
    @(negedge clk);
    chk("sp_valid_t3", 32'(out_valid),   32'd1);
    chk("sp_data_t3",  32'(out_data),    32'hA5);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // fill to 18 words
    for (int i = 0; i < 18; i++) push_word(8'(i));
    in_valid = 1'b1; in_data = 8'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready),  32'd0);
      chk("full_no_wr",    32'(ram_wr_en), 32'd0);
      chk("full_level",    32'(level),     32'd18);
    end
    @(posedge clk); #1 in_valid = 1'b0;

    // drain from full without gaps
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_level", 32'(level),     32'd0);
    chk("empty_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // continuous streaming across pointer wrap
    first = -1; last = -1; vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (c < 40);
      in_data  = 8'h40 + 8'(c);
      @(negedge clk);
      if (c < 40) chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        vcnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(vcnt), 32'd40);
    chk("stream_span",  32'(last - first + 1), 32'd40);

    // reset while a read is in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h60 + 8'(i));
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 8'h70; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("prerst_level",   32'(level),            32'd5);
    chk("prerst_pending", 32'(dut.rd_pending_q), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_level", 32'(level),     32'd0);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    chk("postrst_data",  32'(out_data),  32'd0);
    @(negedge clk);
    chk("postrst_valid2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

`ifdef FIFO_AFULL_EN
    for (int i = 0; i < 11; i++) push_word(8'h80 + 8'(i));
    @(negedge clk);
    chk("af_at11", 32'(almost_full), 32'd0);
    @(posedge clk); #1;
    push_word(8'h8B);
    @(negedge clk);
    chk("af_at12",   32'(almost_full), 32'd1);
    chk("af_level",  32'(level),       32'd12);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("af_pop11",  32'(almost_full), 32'd0);
    chk("af_level11", 32'(level),      32'd11);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Stream-to-RAM controller that sits directly upstream of the 16x8 dual-port RAM and turns it into a synchronous FIFO.
- Accepts a valid/ready write stream and generates the RAM write and read strobes, addresses and data.
- Captures the RAM's 1-cycle-latency read data into a 2-entry output buffer and presents it as a valid/ready read stream.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, RAM address width in bits; the RAM holds 2**DEPTH = 16 entries.

Ports:
- clk  input  1  system clock; every flop is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream consumes the word.
- out_data  output  WIDTH  head-of-FIFO word.
- ram_wr_en  output  1  RAM write strobe.
- ram_wr_addr  output  DEPTH  RAM write address.
- ram_wr_data  output  WIDTH  RAM write data.
- ram_rd_en  output  1  RAM read strobe.
- ram_rd_addr  output  DEPTH  RAM read address.
- ram_rd_data  input  WIDTH  RAM read data, valid the cycle after ram_rd_en.
- level  output  DEPTH+2  total words held (max 18).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, ram_cnt=0, buf_cnt=0, rd_pending=0, out_valid=0, level=0, out_data=0.
- RAM contents are not cleared on reset and are never read before being written.
- Handshakes: push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (ram_cnt != 2**DEPTH). It is combinational from registered state only, never from in_valid.
- Write path, all combinational: ram_wr_en = push, ram_wr_addr = wr_ptr, ram_wr_data = in_data.
- On push, wr_ptr increments and wraps modulo 2**DEPTH.
- Read issue: ram_rd_en = (ram_cnt != 0) && (buf_cnt + rd_pending - pop < 2); ram_rd_addr = rd_ptr.
- On a read issue, rd_ptr increments (wrapping) and rd_pending is set to 1 for the next cycle.
- ram_cnt counts only entries written in earlier cycles, so a word pushed in cycle t is read no earlier than t+1. There is no write-to-read bypass.
- ram_cnt next value = ram_cnt + push - ram_rd_en. Simultaneous push and read leaves ram_cnt unchanged.
- rd_addr never equals wr_addr for a live entry, because a write at ram_cnt == 16 is blocked.
- Output buffer (2 entries, FIFO order): when rd_pending=1, ram_rd_data is captured into the tail.
  - A pop in the same cycle as a capture frees the head first.
  - out_valid = (buf_cnt != 0); out_data = head entry.
  - A popped head exposes the next entry in the following cycle.
- Throughput: with continuous push and out_ready=1, one word per cycle in steady state.
- Latency:
  - A push into an empty FIFO gives out_valid 3 cycles later: write at t, read issue at t+1, capture at t+2, out_valid visible at t+3 (registered).
- level = ram_cnt + buf_cnt + rd_pending, registered.
- Boundary conditions:
  - Full (ram_cnt=16): in_ready=0; an asserted in_valid is held off with no write.
  - Empty with out_ready held high: out_valid=0, no pop.
  - Pointer wrap 15->0 is transparent.
  - Reset mid-operation: a pending read's returning data is discarded, and outputs take their reset values on the next edge.

Optional Feature:
- Macro: FIFO_AFULL_EN.
- Defined:
  - Adds parameter AFULL_THRESH (default 12) and output almost_full (1 bit).
  - almost_full is registered, = (level_next >= AFULL_THRESH), reset 0.
- Undefined: no almost_full port or logic; the rest of the interface is identical.

Decomposition:
- Package fifo_ctrl_pkg:
  - Defaults WIDTH_DEF=8, DEPTH_DEF=4.
  - OBUF_ENTRIES=2.
  - Function for the 2**DEPTH entry count.
- Sub-module out_skid_buf:
  - 2-entry output buffer with capture and pop, exposing buf_cnt, out_valid and out_data.
  - Instantiated once in ram_fifo_ctrl.

Test Plan:
- Reset then idle: level=0, in_ready=1, out_valid=0, ram_wr_en=0, ram_rd_en=0.
- Single push of 8'hA5 at cycle t with out_ready=0: ram_wr_addr=0 at t, ram_rd_en=1 with addr 0 at t+1, out_valid=1 and out_data=8'hA5 at t+3, level=1 throughout.
- Push 18 words 0x00..0x11 with out_ready=0: words 0x00/0x01 fill the output buffer.
  - in_ready drops after the 18th push; ram_cnt=16, level=18.
  - A 19th in_valid is held off with no ram_wr_en.
- From full, out_ready=1 for 18 cycles: out_data sequence 0x00..0x11 in order, no gaps once streaming; level returns to 0.
- Continuous push and pop of 40 incrementing words with out_ready=1:
  - Pointers wrap 15->0 twice.
  - Output order is preserved, one word per cycle in steady state.
- Assert rst for one cycle while rd_pending=1 and level=5: next cycle level=0, out_valid=0; the returning RAM data is not presented.
- FIFO_AFULL_EN build: push 12 words with out_ready=0 gives almost_full=1 on the cycle level reaches 12; pop to 11 gives almost_full=0.
